// File: rtl/pc_sequencer.sv
// Run-control sequencer: clears, advances, jumps or holds the 8-bit PC and strobes instruction commit.
// Optional build macro PC_SEQ_MEM_READY_EN: memory stalls end on MemReady instead of a fixed count.
module pc_sequencer #(
  parameter int unsigned STALL_CYCLES = 4,
  parameter logic [7:0]  PC_MAX       = 8'hFF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [7:0]       PC,
  input  logic             MemOp,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic             HaltOp,
`ifdef PC_SEQ_MEM_READY_EN
  input  logic             MemReady,
`endif
  output logic             PcClear,
  output logic             PcAdvance,
  output logic             PcJump,
  output logic             RegWriteEn,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [7:0]       StallCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       stall_q, stall_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [7:0]       stc_q, stc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             commit;
  logic             stall_done;

`ifdef PC_SEQ_MEM_READY_EN
  assign stall_done = MemReady;
`else
  localparam logic [3:0] STALL_LAST = 4'(STALL_CYCLES - 1);
  assign stall_done = (stall_q == STALL_LAST);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      stall_q <= '0;
      cyc_q   <= '0;
      stc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      cyc_q   <= cyc_d;
      stc_q   <= stc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    cyc_d      = cyc_q;
    stc_d      = stc_q;
    commit     = 1'b0;
    PcClear    = 1'b0;
    PcAdvance  = 1'b0;
    PcJump     = 1'b0;
    RegWriteEn = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_CLEAR;
          cyc_d   = '0;
          stc_d   = '0;
        end
      end
      S_CLEAR: begin
        PcClear = 1'b1;
        state_d = S_RUN;
        cyc_d   = (cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
      end
      S_RUN: begin
        cyc_d = (cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        if (HaltOp) begin
          state_d = S_DONE;
        end else if (MemOp) begin
          stall_d = 4'd1;
          state_d = S_STALL;
        end else begin
          commit = 1'b1;
        end
      end
      S_STALL: begin
        cyc_d   = (cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        stc_d   = (stc_q != 8'hFF) ? stc_q + 8'd1 : stc_q;
        stall_d = (stall_q != 4'hF) ? stall_q + 4'd1 : stall_q;
        commit  = stall_done;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared commit decode for RUN and the final STALL cycle; a commit at PC_MAX ends the run.
    if (commit) begin
      RegWriteEn = 1'b1;
      if (BranchEn && Zero) begin
        PcJump  = 1'b1;
        state_d = S_RUN;
      end else if (PC == PC_MAX) begin
        state_d = S_DONE;
      end else begin
        PcAdvance = 1'b1;
        state_d   = S_RUN;
      end
    end

    // Reset wins the cycle it is asserted in: no PC move or commit escapes.
    if (Reset) begin
      PcClear    = 1'b0;
      PcAdvance  = 1'b0;
      PcJump     = 1'b0;
      RegWriteEn = 1'b0;
    end

    busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_STALL);
    done_d = (state_d == S_DONE);
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign CycleCount = cyc_q;
  assign StallCount = stc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written stall/reset sequences,
// then random stimulus against an instruction-level reference model.
module tb_pc_sequencer;
  localparam int STALL_CYCLES = 4;

  logic        Clk = 1'b0;
  logic        Reset, Start, MemOp, BranchEn, Zero, HaltOp, MemReady;
  logic [7:0]  PC;
  logic        PcClear, PcAdvance, PcJump, RegWriteEn, Busy, Done;
  logic [15:0] CycleCount;
  logic [7:0]  StallCount;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.STALL_CYCLES(STALL_CYCLES), .PC_MAX(8'hFF), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .PC(PC), .MemOp(MemOp),
    .BranchEn(BranchEn), .Zero(Zero), .HaltOp(HaltOp),
`ifdef PC_SEQ_MEM_READY_EN
    .MemReady(MemReady),
`endif
    .PcClear(PcClear), .PcAdvance(PcAdvance), .PcJump(PcJump),
    .RegWriteEn(RegWriteEn), .Busy(Busy), .Done(Done),
    .CycleCount(CycleCount), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  // Reference model: tracks a run in terms of instructions and how many
  // cycles the current memory instruction has already occupied.
  bit          m_busy, m_done, m_clr;
  int          m_mem;
  int unsigned m_cyc, m_stc;
  logic [5:0]  e_flags;
  int unsigned e_cyc, e_stc;

  task automatic model_step(input bit rst, st, input logic [7:0] pc,
                            input bit mop, br, z, hlt, mr);
    bit commit, finish, ready;
    commit = 0; finish = 0;
    e_flags = {4'b0000, m_busy, m_done};
    e_cyc = m_cyc;
    e_stc = m_stc;
    if (rst) begin
      m_busy = 0; m_done = 0; m_clr = 0; m_mem = 0; m_cyc = 0; m_stc = 0;
      return;
    end
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_done = 0; m_clr = 1; m_mem = 0; m_cyc = 0; m_stc = 0;
      end
      return;
    end
    m_cyc = (m_cyc >= 32'd65535) ? 32'd65535 : m_cyc + 1;
    if (m_clr) begin
      e_flags[5] = 1'b1;
      m_clr = 0;
    end else if (m_mem == 0) begin
      if (hlt) finish = 1;
      else if (mop) m_mem = 1;
      else commit = 1;
    end else begin
      m_stc = (m_stc >= 32'd255) ? 32'd255 : m_stc + 1;
`ifdef PC_SEQ_MEM_READY_EN
      ready = mr;
`else
      ready = (m_mem + 1 == STALL_CYCLES);
`endif
      if (ready) begin commit = 1; m_mem = 0; end
      else m_mem = m_mem + 1;
    end
    if (commit) begin
      e_flags[2] = 1'b1;
      if (br && z) e_flags[3] = 1'b1;
      else if (pc == 8'hFF) finish = 1;
      else e_flags[4] = 1'b1;
    end
    if (finish) begin
      m_busy = 0; m_done = 1; m_mem = 0;
    end
  endtask

  task automatic cyc(input bit rst, st, input logic [7:0] pc,
                     input bit mop, br, z, hlt, mr);
    @(posedge Clk);
    #1;
    Reset = rst; Start = st; PC = pc; MemOp = mop;
    BranchEn = br; Zero = z; HaltOp = hlt; MemReady = mr;
    @(negedge Clk);
    model_step(rst, st, pc, mop, br, z, hlt, mr);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int flags();
    return int'({PcClear, PcAdvance, PcJump, RegWriteEn, Busy, Done});
  endfunction

  typedef struct {
    bit         st;
    logic [7:0] pc;
    bit         mop, br, z, hlt, mr;
    logic [5:0] exp;   // {PcClear, PcAdvance, PcJump, RegWriteEn, Busy, Done}
    int         ecyc;  // -1: not checked
    int         estc;
  } vec_t;

  vec_t vq[$];

  initial begin
    Reset = 1; Start = 0; PC = 0; MemOp = 0; BranchEn = 0; Zero = 0; HaltOp = 0; MemReady = 0;

    // Reset state
    cyc(1, 1, 8'h00, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0, 0, 0);
    chk("reset_flags", flags(), 0);
    chk("reset_cyc", int'(CycleCount), 0);
    chk("reset_stc", int'(StallCount), 0);

    //           st pc     mop br z hlt mr  exp        cyc stc
    vq.push_back('{1, 8'h00, 0, 0, 0, 0, 0, 6'b000000,  0,  0});
    vq.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 6'b100010, -1, -1});
    vq.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 6'b010110, -1, -1});
    vq.push_back('{0, 8'h01, 0, 0, 0, 0, 0, 6'b010110, -1, -1});
    vq.push_back('{0, 8'h02, 0, 0, 0, 0, 0, 6'b010110, -1, -1});
    vq.push_back('{0, 8'h03, 0, 0, 0, 1, 0, 6'b000010, -1, -1});
    vq.push_back('{0, 8'h03, 0, 0, 0, 0, 0, 6'b000001,  5,  0});
    vq.push_back('{1, 8'h03, 0, 0, 0, 0, 0, 6'b000001, -1, -1});
    vq.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 6'b100010,  0,  0});
    vq.push_back('{0, 8'h00, 0, 1, 1, 0, 0, 6'b001110, -1, -1});
    vq.push_back('{1, 8'h10, 0, 1, 0, 0, 0, 6'b010110, -1, -1});
    vq.push_back('{0, 8'h11, 1, 0, 0, 0, 0, 6'b000010, -1, -1});
    vq.push_back('{0, 8'h11, 0, 1, 1, 0, 0, 6'b000010, -1, -1});
    vq.push_back('{1, 8'h11, 0, 1, 1, 0, 0, 6'b000010,  5,  1});
    vq.push_back('{0, 8'h11, 0, 1, 1, 0, 1, 6'b001110, -1, -1});
    vq.push_back('{0, 8'h12, 1, 0, 0, 0, 0, 6'b000010, -1, -1});
    vq.push_back('{0, 8'h12, 0, 0, 0, 0, 0, 6'b000010, -1, -1});
    vq.push_back('{0, 8'h12, 0, 0, 0, 0, 0, 6'b000010, -1, -1});
    vq.push_back('{0, 8'h40, 0, 0, 0, 0, 1, 6'b010110, -1, -1});
    vq.push_back('{0, 8'hFF, 0, 0, 0, 0, 0, 6'b000110, -1, -1});
    vq.push_back('{0, 8'hFF, 0, 0, 0, 0, 0, 6'b000001, 12,  6});

    foreach (vq[i]) begin
      cyc(0, vq[i].st, vq[i].pc, vq[i].mop, vq[i].br, vq[i].z, vq[i].hlt, vq[i].mr);
      chk($sformatf("vec%0d_flags", i), flags(), int'(vq[i].exp));
      if (vq[i].ecyc >= 0) chk($sformatf("vec%0d_cyc", i), int'(CycleCount), vq[i].ecyc);
      if (vq[i].estc >= 0) chk($sformatf("vec%0d_stc", i), int'(StallCount), vq[i].estc);
    end

    // Single memory instruction: three quiet cycles, commit on the fourth
    cyc(0, 1, 8'h20, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h20, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h20, 1, 0, 0, 0, 0);
    chk("mem_run_quiet", flags(), 6'b000010);
    cyc(0, 0, 8'h20, 0, 0, 0, 0, 0);
    chk("mem_stall1_quiet", flags(), 6'b000010);
    cyc(0, 0, 8'h20, 0, 0, 0, 0, 0);
    chk("mem_stall2_quiet", flags(), 6'b000010);
    cyc(0, 0, 8'h20, 0, 0, 0, 0, 1);
    chk("mem_commit", flags(), 6'b010110);
    cyc(0, 0, 8'h21, 0, 0, 0, 1, 0);
    chk("mem_stall_count", int'(StallCount), 3);

`ifdef PC_SEQ_MEM_READY_EN
    // MemReady low for six stall cycles, high on the seventh
    cyc(0, 1, 8'h30, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h30, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h30, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 8'h30, 0, 0, 0, 0, 0);
      chk($sformatf("rdy_wait%0d", k), flags(), 6'b000010);
    end
    cyc(0, 0, 8'h30, 0, 0, 0, 0, 1);
    chk("rdy_commit", flags(), 6'b010110);
    cyc(0, 0, 8'h31, 0, 0, 0, 1, 0);
    chk("rdy_stall_count", int'(StallCount), 7);
`endif

    // Start ignored while busy, then reset on what would be the commit cycle
    cyc(0, 1, 8'h50, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h50, 0, 0, 0, 0, 0);
    cyc(0, 0, 8'h50, 1, 0, 0, 0, 0);
    cyc(0, 1, 8'h50, 0, 0, 0, 0, 0);
    cyc(0, 1, 8'h50, 0, 0, 0, 0, 0);
    chk("busy_start_cyc", int'(CycleCount), 3);
    chk("busy_start_stc", int'(StallCount), 1);
    cyc(1, 0, 8'h50, 0, 0, 0, 0, 1);
    chk("reset_cycle_no_commit", flags(), 6'b000010);
    cyc(0, 0, 8'h50, 0, 0, 0, 0, 0);
    chk("post_reset_flags", flags(), 0);
    chk("post_reset_cyc", int'(CycleCount), 0);
    chk("post_reset_stc", int'(StallCount), 0);

    // Random stimulus against the reference model
    for (int n = 0; n < 3000; n++) begin
      bit rst, st, mop, br, z, hlt, mr;
      logic [7:0] pc;
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 5) == 0);
      mop = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 2) == 0);
      z   = $urandom_range(0, 1) == 1;
      hlt = ($urandom_range(0, 15) == 0);
      mr  = ($urandom_range(0, 2) == 0);
      pc  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      cyc(rst, st, pc, mop, br, z, hlt, mr);
      chk($sformatf("rnd%0d_flags", n), flags(), int'(e_flags));
      chk($sformatf("rnd%0d_cyc", n), int'(CycleCount), int'(e_cyc));
      chk($sformatf("rnd%0d_stc", n), int'(StallCount), int'(e_stc));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
